// File: rtl/encoder_onehot_pipe.sv
// ---------------------------------------------------------------------------
// encoder_onehot_pipe
//   Multi-channel pipelined one-hot to binary encoder. Each accepted beat
//   carries NUM_CHANNELS one-hot words. Every word is encoded at acceptance
//   and the result (index, hit, error) is parked in a 2-entry in-order
//   buffer. Per-channel saturating error counters and sticky flags track
//   malformed words for debug.
//
// Ports
//   clk            clock, all state on rising edge
//   reset          synchronous active-high reset
//   i__onehot      NUM_CHANNELS packed words, channel c at [c*NUM_BITS +: NUM_BITS]
//   i__valid       upstream beat valid
//   o__ready       block can accept a beat (registered occupancy < 2)
//   o__valid       output beat valid
//   i__ready       downstream accepts output beat
//   o__encode      encoded index per channel, LOG_NUM_BITS each
//   o__hit         channel produced a usable index
//   o__error       channel word was not strictly one-hot
//   i__err_clear   clear error counters and sticky flags
//   o__err_count   per-channel saturating error counter, ERR_CNT_WIDTH each
//   o__err_sticky  per-channel sticky error flag
// ---------------------------------------------------------------------------
module encoder_onehot_pipe #(
  parameter int NUM_BITS      = 11,
  parameter int LOG_NUM_BITS  = (NUM_BITS == 1) ? 1 : $clog2(NUM_BITS),
  parameter int NUM_CHANNELS  = 4,
  parameter int PRIORITY_MODE = 0,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS*NUM_BITS-1:0]       i__onehot,
  input  logic                                   i__valid,
  output logic                                   o__ready,
  output logic                                   o__valid,
  input  logic                                   i__ready,
  output logic [NUM_CHANNELS*LOG_NUM_BITS-1:0]   o__encode,
  output logic [NUM_CHANNELS-1:0]                o__hit,
  output logic [NUM_CHANNELS-1:0]                o__error,
  input  logic                                   i__err_clear,
  output logic [NUM_CHANNELS*ERR_CNT_WIDTH-1:0]  o__err_count,
  output logic [NUM_CHANNELS-1:0]                o__err_sticky
);

  typedef struct packed {
    logic [NUM_CHANNELS*LOG_NUM_BITS-1:0] encode;
    logic [NUM_CHANNELS-1:0]              hit;
    logic [NUM_CHANNELS-1:0]              error;
  } beat_t;

  beat_t       enc_beat;
  beat_t       mem [2];
  beat_t       head;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  occ;
  logic        accept;
  logic        retire;

  logic [NUM_CHANNELS*ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
  logic [NUM_CHANNELS-1:0]               sticky_q, sticky_d;

  // Ready depends only on registered occupancy (and reset), never on i__ready.
  assign o__ready = !reset && (occ < 2'd2);
  assign o__valid = (occ != 2'd0);
  assign accept   = i__valid && o__ready;
  assign retire   = o__valid && i__ready;

  // Per-channel encode of the incoming beat.
  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    enc_beat = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      logic [NUM_BITS-1:0]     w;
      logic [LOG_NUM_BITS-1:0] lowest;
      logic                    any;
      logic                    multi;
      w      = i__onehot[c*NUM_BITS +: NUM_BITS];
      lowest = '0;
      // Scan downward so the last assignment is the lowest set bit.
      for (int b = NUM_BITS - 1; b >= 0; b--) begin
        if (w[b]) lowest = LOG_NUM_BITS'(b);
      end
      any   = |w;
      // Clearing the lowest set bit leaves something only if >1 bit was set.
      multi = |(w & (w - NUM_BITS'(1)));
      if (PRIORITY_MODE != 0) begin
        enc_beat.hit[c]   = any;
        enc_beat.error[c] = !any || multi;
        enc_beat.encode[c*LOG_NUM_BITS +: LOG_NUM_BITS] = lowest;
      end else begin
        enc_beat.hit[c]   = any && !multi;
        enc_beat.error[c] = !(any && !multi);
        enc_beat.encode[c*LOG_NUM_BITS +: LOG_NUM_BITS] =
          (any && !multi) ? lowest : '0;
      end
    end
  end

  // Buffer control.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (accept) wr_ptr <= ~wr_ptr;
      if (retire) rd_ptr <= ~rd_ptr;
      case ({accept, retire})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible
  // because the outputs are forced to zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= enc_beat;
  end

  assign head      = mem[rd_ptr];
  assign o__encode = o__valid ? head.encode : '0;
  assign o__hit    = o__valid ? head.hit    : '0;
  assign o__error  = o__valid ? head.error  : '0;

  // Error statistics: the clear takes effect first, then an accepted beat
  // is counted on top of it.
  always_comb begin
    err_count_d = err_count_q;
    sticky_d    = sticky_q;
    if (i__err_clear) begin
      err_count_d = '0;
      sticky_d    = '0;
    end
    if (accept) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (enc_beat.error[c]) begin
          sticky_d[c] = 1'b1;
          if (err_count_d[c*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] != '1) begin
            err_count_d[c*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] =
              err_count_d[c*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] + ERR_CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= '0;
      sticky_q    <= '0;
    end else begin
      err_count_q <= err_count_d;
      sticky_q    <= sticky_d;
    end
  end

  assign o__err_count  = err_count_q;
  assign o__err_sticky = sticky_q;

endmodule

// File: tb/tb_encoder_onehot_pipe.sv
// ---------------------------------------------------------------------------
// tb_encoder_onehot_pipe
//   Two instances share all stimulus: a strict-mode encoder with 2-bit error
//   counters (fast saturation) and a priority-mode encoder with 8-bit
//   counters. A reference model pushes expected beats into a queue at each
//   acceptance; a negedge monitor compares whatever the DUTs present.
// ---------------------------------------------------------------------------
module tb_encoder_onehot_pipe;

  localparam int NB  = 11;
  localparam int LG  = 4;
  localparam int NCH = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [NCH*NB-1:0]  i_onehot;
  logic               i_valid;
  logic               i_ready;
  logic               i_err_clear;

  logic               ready_a, valid_a, ready_b, valid_b;
  logic [NCH*LG-1:0]  enc_a, enc_b;
  logic [NCH-1:0]     hit_a, hit_b, err_a, err_b, st_a, st_b;
  logic [NCH*2-1:0]   cnt_a;
  logic [NCH*8-1:0]   cnt_b;

  always #5 clk = ~clk;

  encoder_onehot_pipe #(
    .NUM_BITS(NB), .NUM_CHANNELS(NCH), .PRIORITY_MODE(0), .ERR_CNT_WIDTH(2)
  ) dut_a (
    .clk(clk), .reset(reset), .i__onehot(i_onehot), .i__valid(i_valid),
    .o__ready(ready_a), .o__valid(valid_a), .i__ready(i_ready),
    .o__encode(enc_a), .o__hit(hit_a), .o__error(err_a),
    .i__err_clear(i_err_clear), .o__err_count(cnt_a), .o__err_sticky(st_a)
  );

  encoder_onehot_pipe #(
    .NUM_BITS(NB), .NUM_CHANNELS(NCH), .PRIORITY_MODE(1), .ERR_CNT_WIDTH(8)
  ) dut_b (
    .clk(clk), .reset(reset), .i__onehot(i_onehot), .i__valid(i_valid),
    .o__ready(ready_b), .o__valid(valid_b), .i__ready(i_ready),
    .o__encode(enc_b), .o__hit(hit_b), .o__error(err_b),
    .i__err_clear(i_err_clear), .o__err_count(cnt_b), .o__err_sticky(st_b)
  );

  typedef struct {
    logic [NCH*LG-1:0] enc_a, enc_b;
    logic [NCH-1:0]    hit_a, hit_b, err_a, err_b;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   model_ready = 1'b0;
  int   m_cnt_a[NCH], m_cnt_b[NCH];
  bit   m_st_a[NCH], m_st_b[NCH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the word value.
  function automatic void ref_word(input int w, input bit prio,
                                   output int enc, output bit hit, output bit err);
    int ones = $countones(w);
    int low  = (w == 0) ? 0 : $clog2(w & -w);
    if (prio) begin
      hit = (w != 0);
      enc = (w != 0) ? low : 0;
      err = (ones != 1);
    end else begin
      hit = (ones == 1);
      enc = hit ? low : 0;
      err = !hit;
    end
  endfunction

  // Model: sample inputs at the edge, push expected beat on acceptance.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      for (int c = 0; c < NCH; c++) begin
        m_cnt_a[c] = 0; m_cnt_b[c] = 0; m_st_a[c] = 0; m_st_b[c] = 0;
      end
    end else begin
      if (i_err_clear) begin
        for (int c = 0; c < NCH; c++) begin
          m_cnt_a[c] = 0; m_cnt_b[c] = 0; m_st_a[c] = 0; m_st_b[c] = 0;
        end
      end
      if (i_valid && model_ready) begin
        exp_t e;
        for (int c = 0; c < NCH; c++) begin
          int w, ea, eb;
          bit ha, hb, ra, rb;
          w = int'(i_onehot[c*NB +: NB]);
          ref_word(w, 1'b0, ea, ha, ra);
          ref_word(w, 1'b1, eb, hb, rb);
          e.enc_a[c*LG +: LG] = LG'(ea);
          e.enc_b[c*LG +: LG] = LG'(eb);
          e.hit_a[c] = ha; e.err_a[c] = ra;
          e.hit_b[c] = hb; e.err_b[c] = rb;
          if (ra) begin m_st_a[c] = 1; if (m_cnt_a[c] < 3)   m_cnt_a[c]++; end
          if (rb) begin m_st_b[c] = 1; if (m_cnt_b[c] < 255) m_cnt_b[c]++; end
        end
        q.push_back(e);
      end
    end
  end

  // Monitor: compare mid-cycle, retire the head when the DUT hands it over.
  always @(negedge clk) begin
    logic [NCH*2-1:0] ec_a;
    logic [NCH*8-1:0] ec_b;
    logic [NCH-1:0]   es_a, es_b;
    model_ready = !reset && (q.size() < 2);
    check("ready_a", 64'(ready_a), 64'(model_ready));
    check("ready_b", 64'(ready_b), 64'(model_ready));
    check("valid_a", 64'(valid_a), 64'(q.size() != 0));
    check("valid_b", 64'(valid_b), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("beat_a", {32'(enc_a), 8'(hit_a), 8'(err_a)},
                      {32'(q[0].enc_a), 8'(q[0].hit_a), 8'(q[0].err_a)});
      check("beat_b", {32'(enc_b), 8'(hit_b), 8'(err_b)},
                      {32'(q[0].enc_b), 8'(q[0].hit_b), 8'(q[0].err_b)});
    end else begin
      check("idle_a", {32'(enc_a), 8'(hit_a), 8'(err_a)}, 64'd0);
      check("idle_b", {32'(enc_b), 8'(hit_b), 8'(err_b)}, 64'd0);
    end
    for (int c = 0; c < NCH; c++) begin
      ec_a[c*2 +: 2] = 2'(m_cnt_a[c]);
      ec_b[c*8 +: 8] = 8'(m_cnt_b[c]);
      es_a[c] = m_st_a[c];
      es_b[c] = m_st_b[c];
    end
    check("errcnt_a", 64'(cnt_a), 64'(ec_a));
    check("errcnt_b", 64'(cnt_b), 64'(ec_b));
    check("sticky_a", 64'(st_a), 64'(es_a));
    check("sticky_b", 64'(st_b), 64'(es_b));
    if (q.size() != 0 && i_ready) void'(q.pop_front());
  end

  // Hold a beat until an edge where the block was ready.
  task automatic send(input logic [NCH*NB-1:0] w);
    bit r = 1'b0;
    i_onehot = w;
    i_valid  = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      r = ready_a;
      @(posedge clk);
      #1;
      if (r) break;
    end
    if (!r) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got ready=0 for 100 cycles, expected acceptance");
    end
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [NCH*NB-1:0] pack4(input logic [NB-1:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [NB-1:0] rand_word();
    case ($urandom_range(0, 3))
      0, 1:    return NB'(1) << $urandom_range(0, NB - 1);
      2:       return '0;
      default: return NB'($urandom_range(0, (1 << NB) - 1));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done = 1'b0;
    reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_err_clear = 1'b0;
    i_onehot = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Clean streaming at full throughput.
    for (int i = 0; i < 4; i++)
      send(pack4(11'b100_0000_0000, 11'b1, NB'(1) << (i + 2), NB'(1) << (7 - i)));
    idle(2);

    // Backpressure: two accepted, third held until the stall ends.
    i_ready = 1'b0;
    fork
      begin
        send(pack4(11'h001, 11'h002, 11'h004, 11'h008));
        send(pack4(11'h010, 11'h020, 11'h040, 11'h080));
        send(pack4(11'h100, 11'h200, 11'h400, 11'h001));
        i_valid = 1'b0;
      end
      begin
        repeat (6) begin @(posedge clk); #1; end
        i_ready = 1'b1;
      end
    join
    idle(3);

    // Multi-hot and zero words.
    send(pack4(11'h400, 11'h001, 11'b000_0001_0100, 11'h000));
    idle(2);

    // Saturation on channel 0, then clear coinciding with an errored beat.
    for (int i = 0; i < 5; i++) send(pack4(11'h000, 11'h002, 11'h004, 11'h008));
    i_err_clear = 1'b1;
    send(pack4(11'h000, 11'h002, 11'h004, 11'h008));
    i_err_clear = 1'b0;
    idle(2);
    i_err_clear = 1'b1;
    idle(1);
    i_err_clear = 1'b0;

    // Random traffic with random backpressure and occasional clears.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 4) == 0) idle(1);
          send(pack4(rand_word(), rand_word(), rand_word(), rand_word()));
        end
        i_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          i_ready     = ($urandom_range(0, 3) != 0);
          i_err_clear = ($urandom_range(0, 31) == 0);
        end
        i_ready     = 1'b1;
        i_err_clear = 1'b0;
      end
    join
    idle(4);

    // Reset with two beats buffered, then a fresh beat.
    i_ready = 1'b0;
    send(pack4(11'h000, 11'h003, 11'h004, 11'h008));
    send(pack4(11'h010, 11'h000, 11'h040, 11'h080));
    i_valid = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    i_ready = 1'b1;
    send(pack4(11'h020, 11'h001, 11'h200, 11'h000));
    idle(4);

    check("drain_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/encoder_onehot_pipe.md
Name: encoder_onehot_pipe

Overview:
Multi-channel, pipelined one-hot to binary encoder with a valid/ready handshake and per-channel error tracking. Each accepted beat carries NUM_CHANNELS independent one-hot words. Each word is encoded, flagged as hit or error, and delivered through a 2-entry output buffer. Sits between config/route-select decode logic and downstream consumers that need binary selects, and provides backpressure plus error statistics for debug.

Parameters:
NUM_BITS, 11, width of each one-hot word (>=1)
LOG_NUM_BITS, (NUM_BITS==1) ? 1 : $clog2(NUM_BITS), width of each encoded index
NUM_CHANNELS, 4, number of independent one-hot words per beat (>=1)
PRIORITY_MODE, 0, 0 = strict one-hot; 1 = lowest-set-bit priority encode
ERR_CNT_WIDTH, 8, width of each per-channel saturating error counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
i__onehot  input  NUM_CHANNELS*NUM_BITS  channel c occupies bits [c*NUM_BITS +: NUM_BITS]
i__valid  input  1  upstream beat valid
o__ready  output  1  block can accept a beat
o__valid  output  1  output beat valid
i__ready  input  1  downstream accepts output beat
o__encode  output  NUM_CHANNELS*LOG_NUM_BITS  encoded index per channel
o__hit  output  NUM_CHANNELS  channel produced a usable index
o__error  output  NUM_CHANNELS  channel word was not strictly one-hot
i__err_clear  input  1  clear error counters and sticky flags
o__err_count  output  NUM_CHANNELS*ERR_CNT_WIDTH  per-channel error count
o__err_sticky  output  NUM_CHANNELS  per-channel sticky error flag

Behaviour:
- Reset is synchronous and active-high:
  - buffer emptied; o__valid=0; o__encode, o__hit and o__error all 0.
  - o__err_count=0; o__err_sticky=0.
  - o__ready=0 while reset is high and 1 on the first cycle after it deasserts.
  - A reset mid-stream discards all buffered beats.
- Handshake:
  - A beat is accepted on an edge where i__valid && o__ready.
  - A beat is retired on an edge where o__valid && i__ready.
  - o__ready = (occupancy < 2). It is derived from registered occupancy only, with no combinational path from i__ready.
- Latency: an accepted beat is visible on o__valid at the next edge at the earliest. With i__ready held at 1, throughput is one beat per cycle.
- Buffer:
  - 2-entry FIFO, in-order.
  - Simultaneous accept and retire keeps occupancy unchanged.
  - Accept is impossible when full, because o__ready=0.
  - Retire is impossible when empty, because o__valid=0.
- Output stability: while o__valid && !i__ready, o__encode, o__hit and o__error hold their values.
- Encoding is computed at acceptance and stored in the buffer. Per channel word w:
  - Strict mode (PRIORITY_MODE=0):
    - popcount(w)==1: hit=1, error=0, encode=index of the set bit.
    - Otherwise (zero-hot or multi-hot): hit=0, error=1, encode=0. Never X.
  - Priority mode (PRIORITY_MODE=1):
    - w!=0: hit=1, encode=lowest set index, error=(popcount>1).
    - w==0: hit=0, error=1, encode=0.
- NUM_BITS=1: encode is always 0; hit=w[0]; error=!w[0].
- Error counters:
  - On each accepted beat, every channel whose error=1 increments its counter and sets its sticky bit.
  - Counters saturate at all-ones and do not wrap.
  - Beats that are not accepted, such as i__valid while o__ready=0, are never counted.
- i__err_clear:
  - Clears all counters and sticky bits at the edge.
  - If it coincides with an errored acceptance, the clear applies first and the beat is then counted: that channel's count=1, sticky=1.
  - It does not affect the data path.

Test Plan:
1. Reset, then stream 4 beats with i__ready=1, strict mode, NUM_BITS=11, ch0 = 11'b100_0000_0000, ch1 = 11'b1 -> o__valid on the cycle after each accept; encode ch0=10, ch1=0; hit=1; error=0; o__ready stays 1.
2. Hold i__ready=0 and offer 3 beats -> first 2 accepted; o__ready=0 after occupancy hits 2; third beat is held upstream. Raise i__ready -> the three beats retire in order, and outputs stay stable during the stall.
3. Strict mode, ch2 = 11'b000_0001_0100 and ch3 = 0 -> hit=0, error=1, encode=0 on both channels; err_count ch2=ch3=1; sticky bits set.
4. PRIORITY_MODE=1, word 11'b000_0001_0100 -> hit=1, encode=2, error=1; word 0 -> hit=0, error=1, encode=0.
5. ERR_CNT_WIDTH=2 with 5 errored beats on ch0 -> count reads 1, 2, 3, 3, 3. Assert i__err_clear together with an errored beat -> count=1, sticky=1.
6. Assert reset with 2 beats buffered -> next cycle o__valid=0 and counters 0; o__ready=1 after reset deasserts; a new beat passes with 1-cycle latency.
